sbox_bram_loader: RTL and testbench

- Writer side of the masked S-box BRAM tables. The S-box instances only read these tables through registered dual-port BRAM ports.
- On start, accepts a stream of DEPTH table bytes from a source, e.g. the mask-refresh/table-generation logic, and writes them sequentially into one BRAM write port.
- Then reads the whole table back through a read port with fixed latency and checks an XOR checksum.
- Drives table_ok so the S-box datapath only consumes a table that has been fully written and checked.

---
 rtl/sbox_bram_loader_if.sv | 26 ++
 rtl/sbox_bram_loader.sv | 120 ++++++++++++
 tb/tb_sbox_bram_loader.sv | 260 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/sbox_bram_loader_if.sv
// Source stream and BRAM write/read port bundle for the masked S-box table loader.
// The master is the loader. The slave is the table source together with the BRAM.
interface sbox_bram_loader_if #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 8
);
    logic [DATA_W-1:0] src_data;
    logic              src_valid;
    logic              src_ready;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic              wr_en;
    logic [ADDR_W-1:0] rd_addr;
    logic              rd_en;
    logic [DATA_W-1:0] rd_data;

    modport master (
        input  src_data, src_valid, rd_data,
        output src_ready, wr_addr, wr_data, wr_en, rd_addr, rd_en
    );

    modport slave (
        output src_data, src_valid, rd_data,
        input  src_ready, wr_addr, wr_data, wr_en, rd_addr, rd_en
    );
endinterface

// File: rtl/sbox_bram_loader.sv
// Loads DEPTH S-box table bytes into BRAM, then reads the table back and compares XOR checksums.
// table_ok stays low until a complete load has been verified.
module sbox_bram_loader #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 8,
    parameter int DEPTH  = 1024,
    parameter int RD_LAT = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    sbox_bram_loader_if.master  bus,
    output logic                busy,
    output logic                done,
    output logic                table_ok,
    output logic                err
);

    localparam int CNT_W = ADDR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] LAST_C  = CNT_W'(DEPTH - 1);

    typedef enum logic [1:0] {IDLE, WRITE, VERIFY, CHECK} state_t;

    state_t            state, state_nxt;
    logic [CNT_W-1:0]  wcnt, icnt, rcnt;
    logic [DATA_W-1:0] wsum, rsum, rsum_nxt;
    logic [RD_LAT-1:0] rd_vld;
    logic              hs, capture;

    assign busy = (state != IDLE);
    assign done = (state == CHECK);

    // NOTE: every signal driven here gets a default first, so no path can infer a latch.
    always_comb begin
        bus.src_ready = (state == WRITE) && (wcnt < DEPTH_C);
        hs            = bus.src_valid && bus.src_ready;
        capture       = rd_vld[RD_LAT-1];
        rsum_nxt      = rsum ^ bus.rd_data;
        state_nxt     = state;
        case (state)
            IDLE:    if (start) state_nxt = WRITE;
            WRITE:   if (hs && wcnt == LAST_C) state_nxt = VERIFY;
            VERIFY:  if (capture && rcnt == LAST_C) state_nxt = CHECK;
            CHECK:   state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only, so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst) state <= IDLE;
        else      state <= state_nxt;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            wcnt        <= '0;
            icnt        <= '0;
            rcnt        <= '0;
            wsum        <= '0;
            rsum        <= '0;
            rd_vld      <= '0;
            bus.wr_en   <= 1'b0;
            bus.wr_addr <= '0;
            bus.wr_data <= '0;
            bus.rd_en   <= 1'b0;
            bus.rd_addr <= '0;
            table_ok    <= 1'b0;
            err         <= 1'b0;
        end else begin
            bus.wr_en <= 1'b0;
            bus.rd_en <= 1'b0;
            // Bit k is high when a read issued k+1 cycles ago is outstanding.
            rd_vld[0] <= bus.rd_en;
            for (int i = 1; i < RD_LAT; i++) rd_vld[i] <= rd_vld[i-1];

            case (state)
                IDLE: begin
                    if (start) begin
                        wcnt     <= '0;
                        icnt     <= '0;
                        rcnt     <= '0;
                        wsum     <= '0;
                        rsum     <= '0;
                        table_ok <= 1'b0;
                        err      <= 1'b0;
                    end
                end
                WRITE: begin
                    if (hs) begin
                        bus.wr_en   <= 1'b1;
                        bus.wr_addr <= wcnt[ADDR_W-1:0];
                        bus.wr_data <= bus.src_data;
                        wsum        <= wsum ^ bus.src_data;
                        wcnt        <= wcnt + 1'b1;
                    end
                end
                VERIFY: begin
                    // Entering VERIFY coincides with the final wr_en, so reads start one cycle later.
                    if (icnt < DEPTH_C) begin
                        bus.rd_en   <= 1'b1;
                        bus.rd_addr <= icnt[ADDR_W-1:0];
                        icnt        <= icnt + 1'b1;
                    end
                    if (capture && rcnt < DEPTH_C) begin
                        rsum <= rsum_nxt;
                        rcnt <= rcnt + 1'b1;
                        if (rcnt == LAST_C) begin
                            table_ok <= (rsum_nxt == wsum);
                            err      <= (rsum_nxt != wsum);
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_sbox_bram_loader.sv
// Directed bench for sbox_bram_loader: cycle-exact load/verify timing, backpressure, corruption, restarts.
// Includes a registered two-stage BRAM model and a source that emits entry i as i ^ 8'h5A.
module tb_sbox_bram_loader;

    localparam int N = 1024;

    logic clk, rst, start;
    logic busy, done, table_ok, err;
    int   n_checks, n_fail;

    sbox_bram_loader_if #(.ADDR_W(10), .DATA_W(8)) bus ();

    sbox_bram_loader #(.ADDR_W(10), .DATA_W(8), .DEPTH(N), .RD_LAT(2)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .bus      (bus),
        .busy     (busy),
        .done     (done),
        .table_ok (table_ok),
        .err      (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // BRAM model: address register, then output register.
    logic [7:0] mem [0:N-1];
    logic [9:0] addr_q;
    logic       en_q;
    bit         corrupt;

    always @(posedge clk) begin
        if (bus.wr_en) mem[bus.wr_addr] <= bus.wr_data;
        addr_q <= bus.rd_addr;
        en_q   <= bus.rd_en;
        if (en_q) bus.rd_data <= mem[addr_q] ^ ((corrupt && addr_q == 10'd7) ? 8'h01 : 8'h00);
    end

    task automatic test_reset();
        rst = 1'b0; start = 1'b1; bus.src_valid = 1'b1; bus.src_data = 8'hFF;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            n_checks++;
            if ({bus.src_ready, bus.wr_en, bus.rd_en, busy, done, table_ok, err} !== 7'b0) begin
                n_fail++;
                $display("FAIL reset_flags cyc %0d: got %b expected 0000000", i,
                         {bus.src_ready, bus.wr_en, bus.rd_en, busy, done, table_ok, err});
            end
            n_checks++;
            if ({bus.wr_addr, bus.wr_data, bus.rd_addr} !== 28'd0) begin
                n_fail++;
                $display("FAIL reset_bus cyc %0d: got %h expected 0", i, {bus.wr_addr, bus.wr_data, bus.rd_addr});
            end
        end
        start = 1'b0; bus.src_valid = 1'b0; rst = 1'b1;
        @(negedge clk);
        n_checks++;
        if (busy !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_release_busy: got %b expected 0", busy);
        end
    endtask

    // Runs one load from a start pulse at cycle 0; checks every cycle at the falling edge.
    task automatic run_load(input string name, input bit bp, input int s1, input int s2, input int abort_at,
                            output int first_wr, output int last_wr, output int first_rd,
                            output int last_rd, output int done_cyc);
        int widx, ridx, src_idx;
        bit prev_hs, hs, aborted, exp_ok;
        widx = 0; ridx = 0; src_idx = 0; prev_hs = 1'b0; aborted = 1'b0;
        first_wr = -1; last_wr = -1; first_rd = -1; last_rd = -1; done_cyc = -1;
        exp_ok = !corrupt;
        @(posedge clk); #1;
        for (int k = 0; k < 4000; k++) begin
            start         = (k == 0) || (k == s1) || (k == s2);
            bus.src_valid = bp ? (k % 4 == 0 || k % 4 == 3) : 1'b1;
            bus.src_data  = 8'(src_idx) ^ 8'h5A;
            rst           = (k == abort_at) ? 1'b0 : 1'b1;
            @(negedge clk);
            hs = bus.src_valid && bus.src_ready;
            n_checks++;
            if (busy !== (k >= 1)) begin
                n_fail++;
                $display("FAIL %s busy cyc %0d: got %b expected %b", name, k, busy, k >= 1);
            end
            n_checks++;
            if (bus.src_ready !== (k >= 1 && src_idx < N)) begin
                n_fail++;
                $display("FAIL %s src_ready cyc %0d: got %b expected %b", name, k, bus.src_ready, k >= 1 && src_idx < N);
            end
            n_checks++;
            if (bus.wr_en !== prev_hs) begin
                n_fail++;
                $display("FAIL %s wr_en cyc %0d: got %b expected %b", name, k, bus.wr_en, prev_hs);
            end
            if (bus.wr_en === 1'b1) begin
                n_checks++;
                if (bus.wr_addr !== 10'(widx) || bus.wr_data !== (8'(widx) ^ 8'h5A)) begin
                    n_fail++;
                    $display("FAIL %s write cyc %0d: got addr %0d data %h expected addr %0d data %h",
                             name, k, bus.wr_addr, bus.wr_data, widx, 8'(widx) ^ 8'h5A);
                end
                if (first_wr < 0) first_wr = k;
                last_wr = k;
                widx++;
            end
            if (bus.rd_en === 1'b1) begin
                n_checks++;
                if (bus.rd_addr !== 10'(ridx)) begin
                    n_fail++;
                    $display("FAIL %s rd_addr cyc %0d: got %0d expected %0d", name, k, bus.rd_addr, ridx);
                end
                if (first_rd < 0) first_rd = k;
                last_rd = k;
                ridx++;
            end
            if (k >= 1 && done !== 1'b1) begin
                n_checks++;
                if (table_ok !== 1'b0 || err !== 1'b0) begin
                    n_fail++;
                    $display("FAIL %s status_busy cyc %0d: got ok %b err %b expected 0 0", name, k, table_ok, err);
                end
            end
            if (k == abort_at) begin
                aborted = 1'b1;
                break;
            end
            if (done === 1'b1) begin
                done_cyc = k;
                break;
            end
            prev_hs = hs;
            if (hs) src_idx++;
            @(posedge clk); #1;
        end
        start = 1'b0; bus.src_valid = 1'b0;
        if (aborted) begin
            @(posedge clk); #1;
            rst = 1'b1;
        end else begin
            n_checks++;
            if (done_cyc < 0) begin
                n_fail++;
                $display("FAIL %s timeout: got no done expected done within 4000 cycles", name);
            end
            n_checks++;
            if (widx != N || ridx != N) begin
                n_fail++;
                $display("FAIL %s counts: got writes %0d reads %0d expected %0d %0d", name, widx, ridx, N, N);
            end
            n_checks++;
            if (table_ok !== exp_ok || err !== !exp_ok) begin
                n_fail++;
                $display("FAIL %s result: got ok %b err %b expected ok %b err %b", name, table_ok, err, exp_ok, !exp_ok);
            end
            @(negedge clk);
            n_checks++;
            if (done !== 1'b0 || busy !== 1'b0 || table_ok !== exp_ok) begin
                n_fail++;
                $display("FAIL %s after_done: got done %b busy %b ok %b expected 0 0 %b", name, done, busy, table_ok, exp_ok);
            end
            for (int i = 0; i < N; i++) begin
                n_checks++;
                if (mem[i] !== (8'(i) ^ 8'h5A)) begin
                    n_fail++;
                    $display("FAIL %s mem[%0d]: got %h expected %h", name, i, mem[i], 8'(i) ^ 8'h5A);
                end
            end
        end
    endtask

    task automatic test_nominal();
        int fw, lw, fr, lr, dc;
        run_load("nominal", 1'b0, -1, -1, -1, fw, lw, fr, lr, dc);
        n_checks++;
        if (fw != 2 || lw != 1025 || fr != 1026 || lr != 2049 || dc != 2052) begin
            n_fail++;
            $display("FAIL nominal_timing: got wr %0d..%0d rd %0d..%0d done %0d expected wr 2..1025 rd 1026..2049 done 2052",
                     fw, lw, fr, lr, dc);
        end
    endtask

    task automatic test_backpressure();
        int fw, lw, fr, lr, dc;
        run_load("backpressure", 1'b1, -1, -1, -1, fw, lw, fr, lr, dc);
        n_checks++;
        if (fw != 4 || lw != 2049 || fr != 2050 || lr != 3073 || dc != 3076) begin
            n_fail++;
            $display("FAIL bp_timing: got wr %0d..%0d rd %0d..%0d done %0d expected wr 4..2049 rd 2050..3073 done 3076",
                     fw, lw, fr, lr, dc);
        end
    endtask

    task automatic test_corruption();
        int fw, lw, fr, lr, dc;
        corrupt = 1'b1;
        run_load("corruption", 1'b0, -1, -1, -1, fw, lw, fr, lr, dc);
        corrupt = 1'b0;
        n_checks++;
        if (dc != 2052 || err !== 1'b1 || table_ok !== 1'b0) begin
            n_fail++;
            $display("FAIL corrupt_result: got done %0d err %b ok %b expected done 2052 err 1 ok 0", dc, err, table_ok);
        end
    endtask

    task automatic test_start_during_busy();
        int fw, lw, fr, lr, dc;
        run_load("start_busy", 1'b0, 10, 1500, -1, fw, lw, fr, lr, dc);
        n_checks++;
        if (fw != 2 || lw != 1025 || fr != 1026 || lr != 2049 || dc != 2052 || table_ok !== 1'b1) begin
            n_fail++;
            $display("FAIL start_busy_timing: got wr %0d..%0d rd %0d..%0d done %0d ok %b expected 2..1025 1026..2049 2052 1",
                     fw, lw, fr, lr, dc, table_ok);
        end
    endtask

    task automatic test_reset_midload();
        int fw, lw, fr, lr, dc;
        run_load("abort", 1'b0, -1, -1, 600, fw, lw, fr, lr, dc);
        @(negedge clk);
        n_checks++;
        if ({bus.src_ready, bus.wr_en, bus.rd_en, busy, done, table_ok, err} !== 7'b0) begin
            n_fail++;
            $display("FAIL midreset_flags: got %b expected 0000000",
                     {bus.src_ready, bus.wr_en, bus.rd_en, busy, done, table_ok, err});
        end
        n_checks++;
        if (lw != 600) begin
            n_fail++;
            $display("FAIL midreset_progress: got last write cyc %0d expected 600", lw);
        end
        run_load("reload", 1'b0, -1, -1, -1, fw, lw, fr, lr, dc);
        n_checks++;
        if (fw != 2 || dc != 2052 || table_ok !== 1'b1) begin
            n_fail++;
            $display("FAIL reload_result: got first wr %0d done %0d ok %b expected 2 2052 1", fw, dc, table_ok);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        n_checks = 0; n_fail = 0; corrupt = 1'b0;
        rst = 1'b0; start = 1'b0; bus.src_valid = 1'b0; bus.src_data = '0;
        test_reset();
        test_nominal();
        test_backpressure();
        test_corruption();
        test_start_during_busy();
        test_reset_midload();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
